// File: rtl/regfile_write_arbiter.sv
// Register-file write arbiter with a destination scoreboard.
// Two writeback requesters (ALU, load) share one register-file write port.
// A round-robin pointer breaks ties. A 32-bit pending map tracks issued
// destinations, and decode stalls while it still needs one of them.
module regfile_write_arbiter #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         Issue_Valid_i,
  input  logic [4:0]   Issue_Rd_i,
  input  logic         Wr0_Valid_i,
  input  logic [4:0]   Wr0_Reg_i,
  input  logic [N-1:0] Wr0_Data_i,
  output logic         Wr0_Ready_o,
  input  logic         Wr1_Valid_i,
  input  logic [4:0]   Wr1_Reg_i,
  input  logic [N-1:0] Wr1_Data_i,
  output logic         Wr1_Ready_o,
  output logic         Reg_Write_o,
  output logic [4:0]   Write_Register_o,
  output logic [N-1:0] Write_Data_o,
  input  logic [4:0]   Read_Register_1_i,
  input  logic [4:0]   Read_Register_2_i,
  output logic         Stall_o,
  output logic [31:0]  Pending_o
);

  // prio_q = 0 favours Wr0 on a tie, prio_q = 1 favours Wr1.
  logic          prio_q, prio_d;
  logic [31:0]   pending_q, pending_d;
  logic          reg_write_q, reg_write_d;
  logic [4:0]    wr_reg_q, wr_reg_d;
  logic [N-1:0]  wr_data_q, wr_data_d;

  logic          gnt0, gnt1, handshake;
  logic [4:0]    win_reg;
  logic [N-1:0]  win_data;

  // Grant: a lone requester wins, a tie goes to the one not served last.
  // Nothing is granted while reset is held.
  always_comb begin
    gnt0 = !reset && Wr0_Valid_i && (!Wr1_Valid_i || !prio_q);
    gnt1 = !reset && Wr1_Valid_i && (!Wr0_Valid_i ||  prio_q);
  end

  assign Wr0_Ready_o = gnt0;
  assign Wr1_Ready_o = gnt1;
  assign handshake   = gnt0 || gnt1;
  assign win_reg     = gnt1 ? Wr1_Reg_i  : Wr0_Reg_i;
  assign win_data    = gnt1 ? Wr1_Data_i : Wr0_Data_i;

  // Next state of the write port, pointer and scoreboard.
  always_comb begin
    // NOTE: every combinational output gets a default first so that no
    // path through the block leaves it unassigned, which would infer a latch.
    prio_d      = prio_q;
    pending_d   = pending_q;
    reg_write_d = 1'b0;
    wr_reg_d    = wr_reg_q;
    wr_data_d   = wr_data_q;
    if (handshake) begin
      prio_d      = gnt0;
      reg_write_d = (win_reg != 5'd0);
      wr_reg_d    = win_reg;
      wr_data_d   = win_data;
      if (win_reg != 5'd0) pending_d[win_reg] = 1'b0;
    end
    // A set applied after the clear wins when both target the same register.
    if (Issue_Valid_i && Issue_Rd_i != 5'd0) pending_d[Issue_Rd_i] = 1'b1;
    pending_d[0] = 1'b0;
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      prio_q      <= 1'b0;
      pending_q   <= '0;
      reg_write_q <= 1'b0;
      wr_reg_q    <= '0;
      wr_data_q   <= '0;
    end else begin
      prio_q      <= prio_d;
      pending_q   <= pending_d;
      reg_write_q <= reg_write_d;
      wr_reg_q    <= wr_reg_d;
      wr_data_q   <= wr_data_d;
    end
  end

  // Hazard detect: a source is busy while pending or while its write is
  // still sitting in the output register, one cycle ahead of the regfile.
  always_comb begin
    Stall_o = 1'b0;
    if (Read_Register_1_i != 5'd0 &&
        (pending_q[Read_Register_1_i] ||
         (reg_write_q && wr_reg_q == Read_Register_1_i)))
      Stall_o = 1'b1;
    if (Read_Register_2_i != 5'd0 &&
        (pending_q[Read_Register_2_i] ||
         (reg_write_q && wr_reg_q == Read_Register_2_i)))
      Stall_o = 1'b1;
  end

  assign Reg_Write_o      = reg_write_q;
  assign Write_Register_o = wr_reg_q;
  assign Write_Data_o     = wr_data_q;
  assign Pending_o        = pending_q;

endmodule
